serial_slave_bram_split: RTL and testbench

Serial-bus slave endpoint with an integrated single-port memory, parametrised in address/data width, depth and memory read latency, with optional split-transaction reads. It replaces the fixed-latency slave-plus-BRAM pairing on the serial system bus. It adds in-block serial framing, a `READ_LATENCY`-deep read pipeline, a split/grant handshake for reads, out-of-range address detection and a last-write capture register.

---
 rtl/serial_slave_bram_split.sv | 150 +++++++++++++++
 tb/tb_serial_slave_bram_split.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_bram_split.sv
// Serial-bus slave with integrated single-port memory, a configurable read
// pipeline and an optional split/grant handshake for read returns.
module serial_slave_bram_split #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 1,
  parameter int SPLIT_EN     = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic [DATA_WIDTH-1:0] last_wdata,
  output logic                  addr_err
);

  localparam int MAXN = (ADDR_WIDTH > DATA_WIDTH) ?
                        ((ADDR_WIDTH > READ_LATENCY) ? ADDR_WIDTH : READ_LATENCY) :
                        ((DATA_WIDTH > READ_LATENCY) ? DATA_WIDTH : READ_LATENCY);
  localparam int CW = $clog2(MAXN + 1);
  localparam int MW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, RDREQ, RDWAIT, GRANTWAIT, RDATA
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx, addr_sh;
  logic [DATA_WIDTH-1:0] wdata, wdata_nx, wdata_sh;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  wmode, wmode_nx;
  logic                  in_range, in_range_nx, wen, ren;

  logic [DATA_WIDTH-1:0] mem   [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rpipe [READ_LATENCY];

  assign in_range    = {1'b0, addr} < MEM_LIMIT;
  assign in_range_nx = {1'b0, addr_nx} < MEM_LIMIT;
  assign wen         = (state == WRITE) && in_range;
  assign ren         = (state == RDREQ) && in_range;

  // Memory is never reset; out-of-range addresses never touch it.
  always_ff @(posedge clk) begin
    if (wen) mem[addr[MW-1:0]] <= wdata;
    if (ren) rpipe[0] <= mem[addr[MW-1:0]];
    for (int i = 1; i < READ_LATENCY; i++) rpipe[i] <= rpipe[i-1];
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    wdata_nx = wdata;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    wmode_nx = wmode;
    addr_sh  = addr >> 1;
    addr_sh[ADDR_WIDTH-1] = swdata;
    wdata_sh = wdata >> 1;
    wdata_sh[DATA_WIDTH-1] = swdata;
    case (state)
      IDLE: if (mvalid) begin
        addr_nx  = addr_sh;
        wmode_nx = smode;
        if (ADDR_WIDTH == 1) begin
          cnt_nx   = '0;
          state_nx = smode ? WDATA : RDREQ;
        end else begin
          cnt_nx   = CW'(1);
          state_nx = ADDR;
        end
      end
      ADDR: if (mvalid) begin
        addr_nx = addr_sh;
        if (cnt == CW'(ADDR_WIDTH - 1)) begin
          cnt_nx   = '0;
          state_nx = wmode ? WDATA : RDREQ;
        end else cnt_nx = cnt + CW'(1);
      end
      WDATA: if (mvalid) begin
        wdata_nx = wdata_sh;
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          cnt_nx   = '0;
          state_nx = WRITE;
        end else cnt_nx = cnt + CW'(1);
      end
      WRITE: state_nx = IDLE;
      RDREQ: begin
        cnt_nx   = '0;
        state_nx = RDWAIT;
      end
      RDWAIT: begin
        if (cnt == CW'(READ_LATENCY - 1)) begin
          cnt_nx   = '0;
          shreg_nx = in_range ? rpipe[READ_LATENCY-1] : '0;
          state_nx = (SPLIT_EN != 0) ? GRANTWAIT : RDATA;
        end else cnt_nx = cnt + CW'(1);
      end
      GRANTWAIT: if (split_grant) state_nx = RDATA;
      RDATA: begin
        shreg_nx = shreg >> 1;
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else cnt_nx = cnt + CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      addr       <= '0;
      wdata      <= '0;
      shreg      <= '0;
      cnt        <= '0;
      wmode      <= 1'b0;
      srdata     <= 1'b0;
      svalid     <= 1'b0;
      sready     <= 1'b0;
      ssplit     <= 1'b0;
      last_wdata <= '0;
      addr_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      wdata    <= wdata_nx;
      shreg    <= shreg_nx;
      cnt      <= cnt_nx;
      wmode    <= wmode_nx;
      svalid   <= (state_nx == RDATA);
      srdata   <= (state_nx == RDATA) && shreg_nx[0];
      sready   <= (state_nx == IDLE);
      ssplit   <= (SPLIT_EN != 0) && (state_nx == RDREQ);
      addr_err <= ((state_nx == WRITE) || (state_nx == RDREQ)) && !in_range_nx;
      if (wen) last_wdata <= wdata;
    end
  end

endmodule

// File: tb/tb_serial_slave_bram_split.sv
// Bench for serial_slave_bram_split: a plain slave (RL=2, 3000 words) and a
// split slave (RL=3, 4096 words) share one serial bus and are checked against a model.
module tb_serial_slave_bram_split;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int RL0 = 2;
  localparam int MS0 = 3000;
  localparam int RL1 = 3;
  localparam int MS1 = 4096;

  logic       clk = 1'b0;
  logic       rstn, swdata, smode, mvalid, split_grant;
  logic       srdata_o [2];
  logic       svalid_o [2];
  logic       sready_o [2];
  logic       ssplit_o [2];
  logic       addr_err_o [2];
  logic [7:0] last_wdata_o [2];

  int checks = 0;
  int failures = 0;

  // Reference state: memory image, last write, and addresses known to hold data.
  logic [7:0]  model_mem [2][4096];
  logic [7:0]  model_lw [2];
  logic [11:0] wq [$];
  int          msize [2] = '{MS0, MS1};

  // Per-transaction observations.
  int         cyc = 0;
  int         t_start;
  int         first_v [2], last_v [2], n_v [2];
  int         split_c [2], n_split [2], err_c [2], n_err [2], ready_c [2];
  logic [7:0] rd_bits [2];
  logic [7:0] lw_at_ready [2];

  always #5 clk = ~clk;

  serial_slave_bram_split #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS0),
                            .READ_LATENCY(RL0), .SPLIT_EN(0)) dut0 (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata_o[0]), .svalid(svalid_o[0]), .sready(sready_o[0]),
    .ssplit(ssplit_o[0]), .split_grant(split_grant),
    .last_wdata(last_wdata_o[0]), .addr_err(addr_err_o[0]));

  serial_slave_bram_split #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS1),
                            .READ_LATENCY(RL1), .SPLIT_EN(1)) dut1 (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata_o[1]), .svalid(svalid_o[1]), .sready(sready_o[1]),
    .ssplit(ssplit_o[1]), .split_grant(split_grant),
    .last_wdata(last_wdata_o[1]), .addr_err(addr_err_o[1]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clearRecords();
    for (int i = 0; i < 2; i++) begin
      first_v[i] = -1; last_v[i] = -1; n_v[i] = 0;
      split_c[i] = -1; n_split[i] = 0; err_c[i] = -1; n_err[i] = 0;
      ready_c[i] = -1; rd_bits[i] = '0; lw_at_ready[i] = '0;
    end
  endtask

  // One bus cycle: sample both slaves mid-cycle; the caller then drives this cycle's inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (svalid_o[i]) begin
        if (n_v[i] == 0) first_v[i] = cyc;
        last_v[i] = cyc;
        if (n_v[i] < 8) rd_bits[i][n_v[i][2:0]] = srdata_o[i];
        n_v[i]++;
      end
      if (ssplit_o[i]) begin
        if (n_split[i] == 0) split_c[i] = cyc;
        n_split[i]++;
      end
      if (addr_err_o[i]) begin
        if (n_err[i] == 0) err_c[i] = cyc;
        n_err[i]++;
      end
      if (sready_o[i] && ready_c[i] < 0 && cyc > t_start + 1) begin
        ready_c[i]     = cyc;
        lw_at_ready[i] = last_wdata_o[i];
      end
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [11:0] a, input logic [7:0] d,
                               input int ngaps, input int gdelay);
    logic [19:0] word;
    logic [7:0]  expd;
    int          nb, gsum, t0, gc, n, fv, pos, tend;
    int          gl [20];
    bit          inr;
    word = {d, a};
    nb   = wr ? 20 : 12;
    gsum = 0;
    t0   = 0;
    for (int k = 0; k < 20; k++) gl[k] = 0;
    for (int g = 0; g < ngaps; g++) begin
      pos = int'($urandom_range(nb - 1, 1));
      gl[pos] += int'($urandom_range(4, 1));
    end
    for (int k = 0; k < 20; k++) gsum += gl[k];
    clearRecords();
    t_start = cyc + 1;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < gl[k]; j++) begin
        step();
        mvalid = 1'b0;
        swdata = 1'($urandom_range(1, 0));
        smode  = 1'($urandom_range(1, 0));
      end
      step();
      mvalid = 1'b1;
      swdata = word[k];
      smode  = (k == 0) ? wr : 1'($urandom_range(1, 0));
      if (k == 0) t0 = cyc;
    end
    tend = t0 + AW + gsum;
    gc   = tend + gdelay;
    n    = 0;
    // Bus noise while both slaves are busy, grant raised at gc, plus an ignored early pulse.
    while (!(ready_c[0] >= 0 && ready_c[1] >= 0) && n < 150) begin
      step();
      n++;
      mvalid = (!sready_o[0] && !sready_o[1]) ? 1'($urandom_range(1, 0)) : 1'b0;
      swdata = 1'($urandom_range(1, 0));
      split_grant = !wr && ((cyc >= gc && n_v[1] == 0) || (gdelay > 4 && cyc == tend + 1));
    end
    mvalid      = 1'b0;
    split_grant = 1'b0;
    checkOutput("done_in_budget", 32'(ready_c[0] >= 0 && ready_c[1] >= 0), 1);

    for (int i = 0; i < 2; i++) begin
      inr = (int'(a) < msize[i]);
      if (wr) begin
        if (inr) begin
          model_mem[i][a] = d;
          model_lw[i]     = d;
        end
        checkOutput($sformatf("wr_ready%0d", i), ready_c[i], tend + DW + 1);
        checkOutput($sformatf("wr_nerr%0d", i), n_err[i], inr ? 0 : 1);
        if (!inr) checkOutput($sformatf("wr_errcyc%0d", i), err_c[i], tend + DW);
        checkOutput($sformatf("wr_nvalid%0d", i), n_v[i], 0);
        checkOutput($sformatf("wr_nsplit%0d", i), n_split[i], 0);
      end else begin
        expd = inr ? model_mem[i][a] : 8'h00;
        fv   = (i == 0) ? tend + RL0 + 1 : maxi(gc, tend + RL1 + 1) + 1;
        checkOutput($sformatf("rd_first%0d", i), first_v[i], fv);
        checkOutput($sformatf("rd_last%0d", i), last_v[i], fv + DW - 1);
        checkOutput($sformatf("rd_nvalid%0d", i), n_v[i], DW);
        checkOutput($sformatf("rd_data%0d", i), rd_bits[i], expd);
        checkOutput($sformatf("rd_ready%0d", i), ready_c[i], fv + DW);
        checkOutput($sformatf("rd_nerr%0d", i), n_err[i], inr ? 0 : 1);
        if (!inr) checkOutput($sformatf("rd_errcyc%0d", i), err_c[i], tend);
        checkOutput($sformatf("rd_nsplit%0d", i), n_split[i], i);
        if (i == 1) checkOutput("rd_splitcyc1", split_c[i], tend);
      end
      checkOutput($sformatf("lw_at_ready%0d", i), lw_at_ready[i], model_lw[i]);
    end
    if (wr) wq.push_back(a);
  endtask

  // Write aborted by reset while data bit 4 is on the bus.
  task automatic applyAbort(input logic [11:0] a, input logic [7:0] d);
    logic [19:0] word;
    word = {d, a};
    clearRecords();
    t_start = cyc + 1;
    for (int k = 0; k < 16; k++) begin
      step();
      mvalid = 1'b1;
      swdata = word[k];
      smode  = (k == 0) ? 1'b1 : 1'($urandom_range(1, 0));
    end
    step();
    swdata = word[16];
    rstn   = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("abort_srdata%0d", i), srdata_o[i], 0);
      checkOutput($sformatf("abort_svalid%0d", i), svalid_o[i], 0);
      checkOutput($sformatf("abort_sready%0d", i), sready_o[i], 0);
      checkOutput($sformatf("abort_ssplit%0d", i), ssplit_o[i], 0);
      checkOutput($sformatf("abort_lw%0d", i), last_wdata_o[i], 0);
      checkOutput($sformatf("abort_err%0d", i), addr_err_o[i], 0);
      model_lw[i] = 8'h00;
    end
    step();
    mvalid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    for (int i = 0; i < 2; i++) checkOutput($sformatf("abort_ready%0d", i), sready_o[i], 1);
  endtask

  initial begin
    logic [11:0] ra;
    rstn = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0; split_grant = 1'b0;
    t_start = 1 << 30;
    clearRecords();
    for (int i = 0; i < 2; i++) model_lw[i] = 8'h00;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_srdata%0d", i), srdata_o[i], 0);
      checkOutput($sformatf("rst_svalid%0d", i), svalid_o[i], 0);
      checkOutput($sformatf("rst_sready%0d", i), sready_o[i], 0);
      checkOutput($sformatf("rst_ssplit%0d", i), ssplit_o[i], 0);
      checkOutput($sformatf("rst_lw%0d", i), last_wdata_o[i], 0);
      checkOutput($sformatf("rst_err%0d", i), addr_err_o[i], 0);
    end
    rstn = 1'b1;
    step();
    step();
    for (int i = 0; i < 2; i++) checkOutput($sformatf("idle_ready%0d", i), sready_o[i], 1);

    $display("[TB] directed transactions");
    applyStimulus(1'b1, 12'h0A5, 8'h3C, 0, 0);
    applyStimulus(1'b0, 12'h0A5, 8'h00, 0, 0);
    applyStimulus(1'b1, 12'hFFF, 8'h81, 0, 0);
    applyStimulus(1'b0, 12'hFFF, 8'h00, 0, 14);
    applyStimulus(1'b1, 12'd3000, 8'hFF, 0, 0);
    applyStimulus(1'b0, 12'd3000, 8'h00, 0, 2);
    applyStimulus(1'b1, 12'h123, 8'h5A, 3, 0);
    applyStimulus(1'b0, 12'h123, 8'h00, 3, 6);
    applyAbort(12'h0A5, 8'hC3);
    applyStimulus(1'b0, 12'h0A5, 8'h00, 0, 1);

    $display("[TB] random transactions");
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        applyStimulus(1'b1, 12'($urandom_range(4095, 0)), 8'($urandom_range(255, 0)),
                      int'($urandom_range(3, 0)), 0);
      end else begin
        ra = wq[$urandom_range(wq.size() - 1, 0)];
        applyStimulus(1'b0, ra, 8'h00, int'($urandom_range(3, 0)),
                      int'($urandom_range(12, 0)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
